// File: rtl/nanov_reg_writeback.sv
// nanov_reg_writeback
// Writer end of the bit-serial register file. Takes a parallel word plus a
// destination index and streams it LSB-first into the file. Each stream is
// aligned so that bit 0 lands on rotation position 0. data_rd trails
// data_rd_next by one clock, so a single TAIL clock carries the top bit.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a word; in_ready=1
//   ALIGN | word latched, waiting for rotation position XLEN-1
//   SHIFT | XLEN clocks, one bit per clock on data_rd_next
//   TAIL  | one clock at phase 0 carrying the last bit on data_rd
//
// Writes to x0 are sequenced like any other word, but every enable is held low.

module nanov_reg_writeback #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [XLEN-1:0]             in_data,
  input  logic [REG_AW-1:0]           in_rd,
  output logic [$clog2(XLEN)-1:0]     bit_phase,
  output logic [REG_AW-1:0]           rd,
  output logic                        wr_next_en,
  output logic                        data_rd_next,
  output logic                        wr_en,
  output logic                        data_rd,
  output logic                        read_through,
  output logic                        busy
);

  localparam int PW = $clog2(XLEN);
  localparam logic [PW-1:0] LAST_PHASE = PW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2,
    TAIL  = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] shreg;
  logic            at_last;
  logic            rd_nz;

  assign at_last = (bit_phase == LAST_PHASE);
  assign rd_nz   = |rd;

  // Free-running rotation position; shares the reset edge with the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_phase <= '0;
    end else begin
      bit_phase <= bit_phase + PW'(1);
    end
  end

  // Sequencer: latch the word, align to phase 0, shift it out, then one tail clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      rd         <= '0;
      wr_en      <= 1'b0;
      wr_next_en <= 1'b0;
      data_rd    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      wr_next_en <= 1'b0;
      data_rd    <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            rd    <= in_rd;
            if (at_last) begin
              state      <= SHIFT;
              // rd is being loaded this same edge, so gate on the incoming index
              wr_next_en <= |in_rd;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (at_last) begin
            state      <= SHIFT;
            wr_next_en <= rd_nz;
          end
        end
        SHIFT: begin
          shreg   <= shreg >> 1;
          data_rd <= shreg[0];
          wr_en   <= rd_nz;
          if (at_last) begin
            state <= TAIL;
          end else begin
            wr_next_en <= rd_nz;
          end
        end
        TAIL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and status decode; in_ready deliberately has no path from in_valid.
  always_comb begin
    in_ready     = (state == IDLE) && !rst;
    busy         = (state != IDLE);
    data_rd_next = shreg[0];
    read_through = wr_next_en;
  end

endmodule

// File: tb/tb_nanov_reg_writeback.sv
// Bench for nanov_reg_writeback: a serial register-file model is fed from the
// DUT outputs, and each accepted word is queued and compared when its stream
// ends.

module tb_nanov_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_rd;
  logic [4:0]  bit_phase;
  logic [3:0]  rd;
  logic        wr_next_en;
  logic        data_rd_next;
  logic        wr_en;
  logic        data_rd;
  logic        read_through;
  logic        busy;

  nanov_reg_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_rd        (in_rd),
    .bit_phase    (bit_phase),
    .rd           (rd),
    .wr_next_en   (wr_next_en),
    .data_rd_next (data_rd_next),
    .wr_en        (wr_en),
    .data_rd      (data_rd),
    .read_through (read_through),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
    int          phase;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] mem [16];
  logic [31:0] shadow [16];
  int          n_checks = 0;
  int          n_errors = 0;

  int   nxt_cnt = 0;
  int   wr_cnt = 0;
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: serial register file model and end-of-stream scoreboard
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      nxt_cnt   = 0;
      wr_cnt    = 0;
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      chk("read_through", {31'd0, read_through}, {31'd0, wr_next_en});
      chk("ready_vs_busy", {31'd0, in_ready}, {31'd0, !busy});
      if (wr_next_en) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty_on_write", 32'd0, 32'd1);
        end else begin
          if (nxt_cnt == 0) chk("first_bit_phase", {27'd0, bit_phase}, 32'd0);
          chk("data_rd_next", {31'd0, data_rd_next}, {31'd0, sb_q[0].data[bit_phase]});
          chk("rd_stable", {28'd0, rd}, {28'd0, sb_q[0].rd});
        end
        nxt_cnt++;
      end
      if (wr_en) begin
        logic [4:0] idx;
        idx = bit_phase - 5'd1;
        mem[rd][idx] = data_rd;
        wr_cnt++;
      end
      if (busy) busy_cnt++;
      if (prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty_on_done", 32'd0, 32'd1);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("busy_len", busy_cnt, (31 - e.phase) + 33);
          if (e.rd != 4'd0) begin
            chk("wr_next_cnt", nxt_cnt, 32);
            chk("wr_cnt", wr_cnt, 32);
            chk("reg_readback", mem[e.rd], e.data);
          end else begin
            chk("x0_wr_next_cnt", nxt_cnt, 0);
            chk("x0_wr_cnt", wr_cnt, 0);
            chk("x0_reads_zero", mem[0], 32'd0);
          end
        end
        nxt_cnt  = 0;
        wr_cnt   = 0;
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  // Offer one word at a given rotation phase once the block is idle.
  task automatic send(input logic [3:0] r, input logic [31:0] d, input int ph);
    int   guard;
    sb_t  e;
    guard = 0;
    @(negedge clk);
    while ((busy || bit_phase != ph[4:0]) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("send_timeout", 32'd0, 32'd1);
    e.rd    = r;
    e.data  = d;
    e.phase = ph;
    sb_q.push_back(e);
    shadow[r] = (r == 4'd0) ? 32'd0 : d;
    in_valid = 1'b1;
    in_data  = d;
    in_rd    = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_rd    = 4'($urandom_range(0, 15));
  endtask

  // Count clocks in ALIGN after an accept until the first streamed bit.
  task automatic align_len(output int n);
    n = 0;
    @(negedge clk);
    while (!wr_next_en && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int guard;
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 32'd0;
      shadow[i] = 32'd0;
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'd0;
    in_rd    = 4'd0;

    // 1: reset behaviour and free-running phase
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_enables", {29'd0, wr_en, wr_next_en, read_through}, 32'd0);
    chk("rel_phase0", {27'd0, bit_phase}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("phase_count", {27'd0, bit_phase}, i);
    end

    // 2: directed word offered at phase 10
    send(4'd5, 32'h8000_0001, 10);
    align_len(n);
    chk("align_len_p10", n, 21);
    wait_idle();

    // 3: offered at phase 31, no ALIGN
    send(4'd3, 32'h1234_5678, 31);
    align_len(n);
    chk("align_len_p31", n, 0);
    wait_idle();

    // 4: write to x0
    send(4'd0, 32'hFFFF_FFFF, 4);
    wait_idle();

    // 5: asynchronous reset in the middle of SHIFT
    send(4'd7, 32'hA5A5_5A5A, 20);
    guard = 0;
    @(negedge clk);
    while (!(wr_next_en && bit_phase == 5'd12) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_phase12", {31'd0, wr_next_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", {26'd0, wr_en, wr_next_en, data_rd, data_rd_next, read_through, busy}, 32'd0);
    chk("arst_rd", {28'd0, rd}, 32'd0);
    chk("arst_phase", {27'd0, bit_phase}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    send(4'd7, 32'h0F0F_3C3C, 0);
    wait_idle();

    // 6: random words, indices and phases
    for (int i = 0; i < 200; i++) begin
      send(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 31));
    end
    wait_idle();

    for (int i = 0; i < 16; i++) begin
      chk("final_reg", mem[i], shadow[i]);
    end
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
